// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin CPU/loader arbitration with loader lock,
// read-data return routing after RD_LAT cycles, CPU stall and saturating conflict counter.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              stall0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              last_gnt_q, last_gnt_d;
  logic              lock_q, lock_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RD_LAT-1:0] pv_q, pv_d;   // per-stage read valid
  logic [RD_LAT-1:0] pp_q, pp_d;   // per-stage originating port
  logic              raw_gnt0, raw_gnt1;
  logic              out_valid;

  // Arbitration from registered state; a held lock shuts port 0 out completely.
  always_comb begin
    raw_gnt0 = 1'b0;
    raw_gnt1 = 1'b0;
    if (lock_q && lock1) begin
      raw_gnt1 = req1;
    end else if (req0 && req1) begin
      raw_gnt0 = last_gnt_q;
      raw_gnt1 = ~last_gnt_q;
    end else begin
      raw_gnt0 = req0;
      raw_gnt1 = req1;
    end
  end

  assign gnt0   = raw_gnt0 & ~rst;
  assign gnt1   = raw_gnt1 & ~rst;
  assign stall0 = req0 & ~gnt0;

  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt1) begin
      last_gnt_d = 1'b1;
    end else if (gnt0) begin
      last_gnt_d = 1'b0;
    end

    lock_d = lock_q;
    if (!lock1) begin
      lock_d = 1'b0;
    end else if (gnt1) begin
      lock_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (req0 && req1 && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pv_d    = pv_q << 1;
    pp_d    = pp_q << 1;
    pv_d[0] = mem_en & ~mem_we;
    pp_d[0] = gnt1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      pv_q       <= '0;
      pp_q       <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      pv_q       <= pv_d;
      pp_q       <= pp_d;
    end
  end

  assign out_valid    = pv_q[RD_LAT-1] & ~rst;
  assign rvalid0      = out_valid & ~pp_q[RD_LAT-1];
  assign rvalid1      = out_valid & pp_q[RD_LAT-1];
  assign rdata0       = rvalid0 ? mem_rdata : '0;
  assign rdata1       = rvalid1 ? mem_rdata : '0;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT=1/CNT_W=16 and RD_LAT=2/CNT_W=4) share stimulus,
// each with its own memory, checked every cycle against a rule-level model plus directed cases.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fill;
  logic        req0, we0, req1, we1, lock1;
  logic [13:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;

  logic        gnt0_w [2], gnt1_w [2], stall0_w [2], rv0_w [2], rv1_w [2];
  logic        men_w [2], mwe_w [2];
  logic [31:0] rd0_w [2], rd1_w [2], mwd_w [2], mrd_w [2];
  logic [13:0] mad_w [2];
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_w[0]), .stall0(stall0_w[0]), .rvalid0(rv0_w[0]), .rdata0(rd0_w[0]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1_w[0]), .rvalid1(rv1_w[0]), .rdata1(rd1_w[0]),
    .mem_en(men_w[0]), .mem_we(mwe_w[0]), .mem_addr(mad_w[0]), .mem_wdata(mwd_w[0]),
    .mem_rdata(mrd_w[0]), .conflict_cnt(cnt_a)
  );

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(2), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_w[1]), .stall0(stall0_w[1]), .rvalid0(rv0_w[1]), .rdata0(rd0_w[1]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1_w[1]), .rvalid1(rv1_w[1]), .rdata1(rd1_w[1]),
    .mem_en(men_w[1]), .mem_we(mwe_w[1]), .mem_addr(mad_w[1]), .mem_wdata(mwd_w[1]),
    .mem_rdata(mrd_w[1]), .conflict_cnt(cnt_b)
  );

  function automatic logic [31:0] init_val(input int i);
    case (i)
      16:      return 32'hDEADBEEF;
      4:       return 32'h0404_0404;
      8:       return 32'h0808_0808;
      default: return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Synchronous memories; instance 0 returns data 1 cycle after the access, instance 1 after 2.
  logic [31:0] mem [2][256];
  logic [31:0] r1 [2], r2 [2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (fill) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= init_val(i);
      end else if (men_w[k] && mwe_w[k]) begin
        mem[k][mad_w[k][7:0]] <= mwd_w[k];
      end
      r1[k] <= mem[k][mad_w[k][7:0]];
      r2[k] <= r1[k];
    end
  end
  assign mrd_w[0] = r1[0];
  assign mrd_w[1] = r2[1];

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: rule-level arbitration, a due-cycle map for read returns, plain counters.
  typedef struct packed {logic port; logic [31:0] data;} rd_t;
  rd_t         due [int];
  logic [31:0] ref_mem [256];

  initial begin
    int cyc, key;
    bit model_ok, last, owner, eg0, eg1, e_we;
    int cnt [2];
    int cmax [2];
    logic [13:0] e_addr;
    logic [31:0] e_wd;
    rd_t e;
    cyc = 0;
    model_ok = 0;
    last = 1;
    owner = 0;
    cmax[0] = 65535;
    cmax[1] = 15;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("u%0d rst gnt0", k), gnt0_w[k], 0);
          check($sformatf("u%0d rst gnt1", k), gnt1_w[k], 0);
          check($sformatf("u%0d rst mem_en", k), men_w[k], 0);
          check($sformatf("u%0d rst rvalid0", k), rv0_w[k], 0);
          check($sformatf("u%0d rst rvalid1", k), rv1_w[k], 0);
          check($sformatf("u%0d rst rdata0", k), rd0_w[k], 0);
          check($sformatf("u%0d rst rdata1", k), rd1_w[k], 0);
          check($sformatf("u%0d rst stall0", k), stall0_w[k], req0);
          if (model_ok) check($sformatf("u%0d rst cnt", k), (k == 0) ? cnt_a : cnt_b, cnt[k]);
        end
        last = 1;
        owner = 0;
        cnt[0] = 0;
        cnt[1] = 0;
        due.delete();
        model_ok = 1;
      end else if (model_ok) begin
        if (owner && lock1) begin
          eg0 = 0;
          eg1 = req1;
        end else if (req0 && req1) begin
          eg0 = (last == 1);
          eg1 = (last == 0);
        end else begin
          eg0 = req0;
          eg1 = req1;
        end
        e_we   = eg0 ? we0 : (eg1 ? we1 : 1'b0);
        e_addr = eg0 ? addr0 : (eg1 ? addr1 : 14'd0);
        e_wd   = eg0 ? wdata0 : (eg1 ? wdata1 : 32'd0);
        for (int k = 0; k < 2; k++) begin
          check($sformatf("u%0d gnt0", k), gnt0_w[k], eg0);
          check($sformatf("u%0d gnt1", k), gnt1_w[k], eg1);
          check($sformatf("u%0d stall0", k), stall0_w[k], req0 && !eg0);
          check($sformatf("u%0d mem_en", k), men_w[k], eg0 || eg1);
          check($sformatf("u%0d mem_we", k), mwe_w[k], e_we);
          check($sformatf("u%0d mem_addr", k), mad_w[k], e_addr);
          check($sformatf("u%0d mem_wdata", k), mwd_w[k], e_wd);
          check($sformatf("u%0d cnt", k), (k == 0) ? cnt_a : cnt_b, cnt[k]);
          key = cyc * 2 + k;
          if (due.exists(key)) begin
            e = due[key];
            check($sformatf("u%0d rvalid0", k), rv0_w[k], !e.port);
            check($sformatf("u%0d rvalid1", k), rv1_w[k], e.port);
            check($sformatf("u%0d rdata0", k), rd0_w[k], e.port ? 32'd0 : e.data);
            check($sformatf("u%0d rdata1", k), rd1_w[k], e.port ? e.data : 32'd0);
            due.delete(key);
          end else begin
            check($sformatf("u%0d rvalid0 idle", k), rv0_w[k], 0);
            check($sformatf("u%0d rvalid1 idle", k), rv1_w[k], 0);
          end
        end
        if (eg0 || eg1) begin
          last = eg1;
          if (e_we) begin
            ref_mem[e_addr[7:0]] = e_wd;
          end else begin
            for (int k = 0; k < 2; k++) due[(cyc + k + 1) * 2 + k] = '{port: eg1, data: ref_mem[e_addr[7:0]]};
          end
        end
        owner = !lock1 ? 1'b0 : (eg1 ? 1'b1 : owner);
        for (int k = 0; k < 2; k++) if (req0 && req1 && cnt[k] < cmax[k]) cnt[k]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    lock1 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    bit h0, h1;
    idle();
    rst  = 1;
    fill = 1;
    step();
    fill = 0;
    step();
    rst = 0;

    // Single CPU read
    req0 = 1; addr0 = 14'h010;
    #2;
    check("t1 gnt0", gnt0_w[0], 1);
    check("t1 mem_addr", mad_w[0], 14'h010);
    step();
    req0 = 0;
    #2;
    check("t1 u1 rvalid0", rv0_w[0], 1);
    check("t1 u1 rdata0", rd0_w[0], 32'hDEADBEEF);
    check("t1 u1 rvalid1", rv1_w[0], 0);
    step();
    #2;
    check("t1 u2 rvalid0", rv0_w[1], 1);
    check("t1 u2 rdata0", rd0_w[1], 32'hDEADBEEF);

    // Tie after reset: 0,1,0,1
    do_reset();
    req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check($sformatf("t2 gnt0 c%0d", i + 1), gnt0_w[0], (i % 2) == 0);
      check($sformatf("t2 stall0 c%0d", i + 1), stall0_w[0], (i % 2) == 1);
      step();
    end
    idle();
    #2;
    check("t2 cnt u1", cnt_a, 4);
    check("t2 cnt u2", cnt_b, 4);
    step();

    // Loader lock after a CPU access has set last_gnt to 0
    do_reset();
    req0 = 1; addr0 = 14'h020;
    step();
    req1 = 1; lock1 = 1; we1 = 1;
    for (int i = 0; i < 4; i++) begin
      addr1 = 14'(i);
      wdata1 = $urandom;
      #2;
      check($sformatf("t3 gnt1 c%0d", i + 1), gnt1_w[0], 1);
      check($sformatf("t3 gnt0 c%0d", i + 1), gnt0_w[0], 0);
      check($sformatf("t3 stall0 c%0d", i + 1), stall0_w[0], 1);
      step();
    end
    lock1 = 0; req1 = 0;
    #2;
    check("t3 gnt0 after unlock", gnt0_w[0], 1);
    step();

    // Interleaved reads, RD_LAT = 2
    do_reset();
    req0 = 1; addr0 = 14'h004;
    step();
    req0 = 0; req1 = 1; addr1 = 14'h008;
    step();
    req1 = 0;
    #2;
    check("t4 c3 rvalid0", rv0_w[1], 1);
    check("t4 c3 rdata0", rd0_w[1], 32'h0404_0404);
    check("t4 c3 rvalid1", rv1_w[1], 0);
    step();
    #2;
    check("t4 c4 rvalid1", rv1_w[1], 1);
    check("t4 c4 rdata1", rd1_w[1], 32'h0808_0808);
    check("t4 c4 rvalid0", rv0_w[1], 0);
    step();

    // Reset mid-read
    do_reset();
    req0 = 1; addr0 = 14'h010;
    #2;
    check("t5 gnt0", gnt0_w[0], 1);
    step();
    req0 = 0; rst = 1;
    #2;
    check("t5 u1 rvalid0", rv0_w[0], 0);
    step();
    rst = 0;
    #2;
    check("t5 u2 rvalid0", rv0_w[1], 0);
    check("t5 cnt", cnt_a, 0);
    step();
    req0 = 1; req1 = 1;
    #2;
    check("t5 tie gnt0", gnt0_w[0], 1);
    step();

    // Counter saturation
    do_reset();
    req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    repeat (20) step();
    idle();
    #2;
    check("t6 cnt u2 sat", cnt_b, 15);
    check("t6 cnt u1", cnt_a, 20);
    step();

    // Randomized traffic; ungranted requests keep their command fields
    #2;
    for (int n = 0; n < 3000; n++) begin
      h0 = req0 && !gnt0_w[0];
      h1 = req1 && !gnt1_w[0];
      step();
      rst = ($urandom_range(0, 199) == 0);
      if (h0) begin
        req0 = ($urandom_range(0, 7) != 0);
      end else begin
        req0 = $urandom_range(0, 1); we0 = $urandom_range(0, 1);
        addr0 = 14'($urandom_range(0, 255)); wdata0 = $urandom;
      end
      if (h1) begin
        req1 = ($urandom_range(0, 7) != 0);
      end else begin
        req1 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
        addr1 = 14'($urandom_range(0, 255)); wdata1 = $urandom;
      end
      if ($urandom_range(0, 9) == 0) lock1 = !lock1;
      #2;
    end
    idle();
    rst = 0;
    repeat (4) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
